// File: rtl/wb_port_sched.sv
// Writeback-port scheduler: arbitrates ALU and load results onto one RF write port.
// Define WB_RR_ARB_EN for round-robin conflict arbitration (default: loads win).
module wb_port_sched #(
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS),
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic          alu_dual,
    input  logic [AW-1:0] alu_dst0,
    input  logic [DW-1:0] alu_data0,
    input  logic [AW-1:0] alu_dst1,
    input  logic [DW-1:0] alu_data1,
    input  logic          alu_last,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_dst,
    input  logic [DW-1:0] mem_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          clr_valid,
    output logic [AW-1:0] clr_addr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        HALT
    } state_t;

    state_t        state;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic          idle;
    logic          alu_wins;
    logic          alu_acc;
    logic          mem_acc;

`ifdef WB_RR_ARB_EN
    logic last_alu;

    assign alu_wins = !last_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_alu <= 1'b1;
        end else if (alu_acc) begin
            last_alu <= 1'b1;
        end else if (mem_acc) begin
            last_alu <= 1'b0;
        end
    end
`else
    assign alu_wins = 1'b0;
`endif

    // Each ready looks only at the other side's valid.
    assign idle      = (state == IDLE) && !reset;
    assign alu_ready = idle && (!mem_valid || alu_wins);
    assign mem_ready = idle && (!alu_valid || !alu_wins);
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;

    assign clr_valid = rf_we;
    assign clr_addr  = rf_waddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rf_we <= alu_acc || mem_acc;
                    if (alu_acc) begin
                        rf_waddr <= alu_dst0;
                        rf_wdata <= alu_data0;
                        if (alu_dual) begin
                            hold_addr <= alu_dst1;
                            hold_data <= alu_data1;
                            hold_last <= alu_last;
                            busy      <= 1'b1;
                            state     <= SECOND;
                        end else if (alu_last) begin
                            state <= HALT;
                        end
                    end else if (mem_acc) begin
                        rf_waddr <= mem_dst;
                        rf_wdata <= mem_data;
                    end
                end
                SECOND: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= hold_addr;
                    rf_wdata <= hold_data;
                    busy     <= 1'b0;
                    state    <= hold_last ? HALT : IDLE;
                end
                HALT: begin
                    rf_we <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    rf_we <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_sched.sv
// Scoreboard bench for wb_port_sched: directed cases plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_wb_port_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, alu_dual, alu_last;
    logic [3:0]  alu_dst0, alu_dst1, mem_dst;
    logic [63:0] alu_data0, alu_data1, mem_data;
    logic        mem_valid, mem_ready;
    logic        rf_we, clr_valid, busy, done;
    logic [3:0]  rf_waddr, clr_addr;
    logic [63:0] rf_wdata;

    wb_port_sched #(.NREGS(16), .AW(4), .DW(64)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dual(alu_dual),
        .alu_dst0(alu_dst0), .alu_data0(alu_data0),
        .alu_dst1(alu_dst1), .alu_data1(alu_data1), .alu_last(alu_last),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dst(mem_dst), .mem_data(mem_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .clr_valid(clr_valid), .clr_addr(clr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  a;
        logic [63:0] d;
    } wr_t;

    wr_t         q[$];
    int          vectors = 0;
    int          fails = 0;
    logic [63:0] shadow[16];

    // Transaction-level model state
    bit m_second, m_sec_last, m_halt, m_last_alu;
    int m_done_from;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Monitor: pops the expected write whenever the port fires.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cycle) begin
            vectors++;
            fails++;
            $display("FAIL missed_write @cycle %0d: got none expected %0h<=%0h at %0d",
                     cycle, q[0].a, q[0].d, q[0].cyc);
            void'(q.pop_front());
        end
        if (rf_we === 1'b1) begin
            shadow[rf_waddr] = rf_wdata;
            if (q.size() == 0 || q[0].cyc != cycle) begin
                vectors++;
                fails++;
                $display("FAIL extra_write @cycle %0d: got %0h<=%0h expected none",
                         cycle, rf_waddr, rf_wdata);
            end else begin
                chk("waddr", {60'd0, rf_waddr}, {60'd0, q[0].a});
                chk("wdata", rf_wdata, q[0].d);
                void'(q.pop_front());
            end
        end
        if (cycle > 0) begin
            chk("clr_valid", {63'd0, clr_valid}, {63'd0, rf_we});
            chk("clr_addr", {60'd0, clr_addr}, {60'd0, rf_waddr});
        end
    end

    task automatic model_reset();
        m_second    = 0;
        m_sec_last  = 0;
        m_halt      = 0;
        m_last_alu  = 1;
        m_done_from = 32'h7fff_ffff;
    endtask

    task automatic step(input logic av, input logic dl,
                        input logic [3:0] d0, input logic [63:0] x0,
                        input logic [3:0] d1, input logic [63:0] x1,
                        input logic lst, input logic mv,
                        input logic [3:0] md, input logic [63:0] mx);
        bit avail, pri, ea, em;
        @(posedge clk);
        #1;
        reset = 0;
        alu_valid = av; alu_dual = dl; alu_last = lst;
        alu_dst0 = d0; alu_data0 = x0; alu_dst1 = d1; alu_data1 = x1;
        mem_valid = mv; mem_dst = md; mem_data = mx;
        @(negedge clk);
        #1;
        avail = !m_halt && !m_second;
`ifdef WB_RR_ARB_EN
        pri = !m_last_alu;
`else
        pri = 0;
`endif
        ea = avail && (!mv || pri);
        em = avail && (!av || !pri);
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, ea});
        chk("mem_ready", {63'd0, mem_ready}, {63'd0, em});
        chk("busy", {63'd0, busy}, {63'd0, m_second});
        chk("done", {63'd0, done}, {63'd0, (cycle >= m_done_from)});
        if (m_second) begin
            m_second = 0;
            if (m_sec_last) begin
                m_halt = 1;
                m_done_from = cycle + 2;
            end
        end
        if (av && ea) begin
            q.push_back('{cycle + 1, d0, x0});
            m_last_alu = 1;
            if (dl) begin
                q.push_back('{cycle + 2, d1, x1});
                m_second = 1;
                m_sec_last = lst;
            end else if (lst) begin
                m_halt = 1;
                m_done_from = cycle + 2;
            end
        end else if (mv && em) begin
            q.push_back('{cycle + 1, md, mx});
            m_last_alu = 0;
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One reset cycle with valids raised, then one quiet cycle checking reset values.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1;
        alu_valid = 1; mem_valid = 1; alu_dual = 0; alu_last = 0;
        @(negedge clk);
        #1;
        chk("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].cyc > cycle) q.delete(i);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        #1;
        chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_rf_waddr", {60'd0, rf_waddr}, 64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        chk("rst_clr_valid", {63'd0, clr_valid}, 64'd0);
        chk("rst_clr_addr", {60'd0, clr_addr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        alu_valid = 0; alu_dual = 0; alu_last = 0; mem_valid = 0;
        alu_dst0 = 0; alu_dst1 = 0; mem_dst = 0;
        alu_data0 = 0; alu_data1 = 0; mem_data = 0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        model_reset();
        do_reset();

        // Single ALU write
        step(1, 0, 3, 64'hAA, 0, 0, 0, 0, 0, 0);
        idle_step();
        idle_step();

        // Dual write
        step(1, 1, 0, 64'h11, 2, 64'h22, 0, 0, 0, 0);
        step(1, 0, 7, 64'h77, 0, 0, 0, 1, 9, 64'h99);
        idle_step();
        idle_step();

        // Conflict burst after reset
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, 0, 6, 64'h600 + i, 0, 0, 0, 1, 5, 64'h500 + i);
        idle_step();
        idle_step();

        // Same destination dual
        step(1, 1, 4, 64'h1, 4, 64'h2, 0, 0, 0, 0);
        idle_step();
        idle_step();
        chk("reg4_final", shadow[4], 64'h2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                 4'($urandom), {$urandom, $urandom},
                 4'($urandom), {$urandom, $urandom},
                 0, $urandom_range(0, 1),
                 4'($urandom), {$urandom, $urandom});
        end
        idle_step();
        idle_step();
        idle_step();
        chk("drain_q", q.size(), 0);

        // Reset in the middle of a dual write
        step(1, 1, 8, 64'h88, 9, 64'h99, 0, 0, 0, 0);
        do_reset();
        idle_step();

        // End of simulation, then valids ignored
        step(1, 0, 1, 64'hE1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 2, 64'hBAD, 0, 0, 0, 1, 3, 64'hBAD);
        chk("halt_done", {63'd0, done}, 64'd1);

        // Dual with end marker
        do_reset();
        step(1, 1, 10, 64'hA0, 11, 64'hB0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 2, 64'hBAD, 0, 0, 0, 1, 3, 64'hBAD);

        // Resume after reset from HALT
        do_reset();
        step(1, 0, 12, 64'hC0, 0, 0, 0, 1, 13, 64'hD0);
        idle_step();
        idle_step();
        chk("final_q", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/wb_port_sched.md
# wb_port_sched

Writeback-port scheduler between the execute/memory stages and the register file. Arbitrates the single register-file write port between the ALU result path and the load-return path, and splits dual-destination ALU results (opcode 247, RAX:RDX) into two back-to-back port writes. Emits one scoreboard-clear pulse per write and latches end-of-simulation after the final write drains.

## Interface

- NREGS, 16, number of architectural registers
- AW, 4, register index width (log2 NREGS)
- DW, 64, data width

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_dual  in  1  result has a second destination
- alu_dst0  in  AW  first destination index
- alu_data0  in  DW  first data (alu_result)
- alu_dst1  in  AW  second destination index (valid if alu_dual)
- alu_data1  in  DW  second data (alu_ext_result)
- alu_last  in  1  instruction carries sim_end
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when high with mem_valid
- mem_dst  in  AW  load destination index
- mem_data  in  DW  load data
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  write index
- rf_wdata  out  DW  write data
- clr_valid  out  1  scoreboard clear pulse, equals rf_we
- clr_addr  out  AW  scoreboard index, equals rf_waddr
- busy  out  1  high in SECOND state
- done  out  1  sticky end-of-simulation flag

## Operation

- States: IDLE, SECOND, HALT.
- IDLE: grant computed combinationally from alu_valid/mem_valid. One valid -> that side ready. Both valid -> priority rule (Configuration). Ready of the non-granted side low. Readies never depend on their own valid.
- Accept = valid && ready. Accepted request's dst/data registered to rf_* for next cycle.
- ALU accept with alu_dual=1: store dst1/data1 in holding register, go SECOND.
- SECOND: both readies low; holding register drives rf_* next cycle; return to IDLE (or HALT if alu_last).
- ALU accept with alu_last=1 and alu_dual=0: go HALT after its write is issued.
- HALT: both readies low permanently; rf_we 0 after last write; done=1 from the cycle after the final write; leave only via reset.
- alu_dst0 == alu_dst1: both writes issued in order; dst1 value is final.
- rf_we/clr_valid deassert in any cycle with no accept and no held second write.
- Width: indices outside NREGS-1 are not possible (AW exact); no arithmetic beyond holding-register moves.

## Timing

- Reset values: alu_ready 0, mem_ready 0 during reset cycle; rf_we 0, rf_waddr 0, rf_wdata 0, clr_valid 0, clr_addr 0, busy 0, done 0; state IDLE; RR pointer "ALU last granted".
- Latency: accept in cycle N -> rf_we=1 in N+1. Dual: first write N+1, second write N+2, busy=1 in N+1.
- Throughput: one single write per cycle sustained; dual costs two cycles.
- Reset asserted in SECOND: held second write discarded; rf_we 0 in next cycle.
- Reset asserted in HALT: done clears next cycle, readies resume after reset deasserts.
- clr_valid/clr_addr identical to rf_we/rf_waddr every cycle.

## Configuration

- WB_RR_ARB_EN defined: round-robin on conflict; the side not granted last wins; pointer updates on every accept to the accepted side; first conflict after reset goes to mem.
- Undefined: fixed priority, mem always wins conflicts; ALU may starve while loads stream.

## Test plan

- Single ALU: alu_valid, dst0=3, data0=0xAA at N -> rf_we=1, waddr=3, wdata=0xAA, clr_addr=3 at N+1; idle after.
- Dual: alu_dual, dst0=0/0x11, dst1=2/0x22 at N -> writes (0,0x11) at N+1, (2,0x22) at N+2; alu_ready=mem_ready=0 and busy=1 at N+1.
- Conflict: both valid for 4 cycles (mem_dst=5, alu_dst0=6) -> fixed: four writes to 5; WB_RR_ARB_EN: 5,6,5,6.
- End: alu_last, dst0=1 at N -> write at N+1, done=1 from N+2, readies 0 indefinitely despite valids.
- Reset mid-dual: dual accept at N, reset at N+1 -> no write at N+2, all outputs at reset values.
- Same-dst dual: dst0=dst1=4, data 0x1/0x2 -> reg 4 final 0x2, two clr pulses on 4.
